// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART receive (and later transmit) path.
//   rx_state_t : receiver FSM state encoding
//   DATA_BITS  : payload width of one character
//   calc_div   : system clocks per oversample tick
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Integer division on purpose: the residual baud error is absorbed by
    // re-aligning every frame to its own start edge.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
// Receive-side bundle between the UART receiver and the IO-bus register file.
//   rx_data   : last correctly received byte
//   rx_busy   : frame in progress
//   rx_valid  : one-cycle pulse when rx_data is updated
//   frame_err : one-cycle pulse on a rejected frame
// Modports: master (receiver drives), slave (register file observes).
// ---------------------------------------------------------------------------
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_busy;
    logic                 rx_valid;
    logic                 frame_err;

    modport master (
        output rx_data,
        output rx_busy,
        output rx_valid,
        output frame_err
    );

    modport slave (
        input rx_data,
        input rx_busy,
        input rx_valid,
        input frame_err
    );

endinterface

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Divides the system clock into a one-cycle oversample tick.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   clear : holds the divider at 0 (phase re-alignment)
//   tick  : one-cycle pulse every DIV clocks, at count DIV-1
// Written standalone so the transmitter can reuse it.
// ---------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int              CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_baud_gen: DIV must be at least 2");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count and tick; clear wins so the first tick after a clear comes
    // a full DIV clocks later.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            tick  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Serial receive front end: synchronises rxd, oversamples each bit,
// majority-votes three samples around mid-bit and checks the stop bit.
//   clk    : system clock
//   reset  : asynchronous active-high reset
//   rxd    : asynchronous serial input, idle high
//   rx_if  : uart_rx_if.master (rx_data, rx_busy, rx_valid, frame_err)
// Optional build macro UART_RX_PARITY_EN adds an even-parity bit
// (11-bit frames); undefined gives plain 8N1.
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      rxd,
    uart_rx_if.master rx_if
);

    localparam int DIV    = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int SAMP_W = $clog2(OVERSAMPLE);
    localparam int IDX_W  = $clog2(DATA_BITS);

    localparam logic [SAMP_W-1:0] SAMP_EARLY = SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMP_W-1:0] SAMP_MID   = SAMP_W'(OVERSAMPLE / 2);
    localparam logic [SAMP_W-1:0] SAMP_LATE  = SAMP_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST  = SAMP_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DATA_BITS - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_rx: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 2");
    end
    if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
        $error("uart_rx: OVERSAMPLE must be even and at least 8");
    end

    logic rxd_meta_q;
    logic rxs_q;
    logic rxs_prev_q;

    rx_state_t            state_q,   state_d;
    logic [SAMP_W-1:0]    samp_q,    samp_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic                 vote_a_q,  vote_a_d;
    logic                 vote_b_q,  vote_b_d;
    logic [DATA_BITS-1:0] data_q,    data_d;
    logic                 busy_q,    busy_d;
    logic                 valid_q,   valid_d;
    logic                 ferr_q,    ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_err_q, par_err_d;
`endif

    logic tick;
    logic vote;
    logic decide;
    logic bit_end;

    // Two-flop synchroniser plus one history flop for falling-edge detect.
    // All three reset to the idle-line level so reset never fakes a start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_meta_q <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxs_q      <= rxd_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    // Divider is parked in IDLE, so the first tick of every frame lands a
    // fixed DIV clocks after the start edge was seen.
    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud_gen (
        .clk   (clk),
        .reset (reset),
        .clear (state_q == IDLE),
        .tick  (tick)
    );

    // The third vote is the live sample taken at the decision tick itself.
    assign vote    = (vote_a_q & vote_b_q) | (vote_a_q & rxs_q) | (vote_b_q & rxs_q);
    assign decide  = tick && (samp_q == SAMP_LATE);
    assign bit_end = tick && (samp_q == SAMP_LAST);

    // Next-state logic: sample counter, vote capture, shift register and the
    // frame FSM. Pulses default low so they are exactly one cycle wide.
    always_comb begin
        state_d   = state_q;
        samp_d    = samp_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        vote_a_d  = vote_a_q;
        vote_b_d  = vote_b_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif

        if (tick) begin
            samp_d = (samp_q == SAMP_LAST) ? '0 : samp_q + 1'b1;
            if (samp_q == SAMP_EARLY) begin
                vote_a_d = rxs_q;
            end
            if (samp_q == SAMP_MID) begin
                vote_b_d = rxs_q;
            end
        end

        case (state_q)
            IDLE: begin
                samp_d    = '0;
                bit_idx_d = '0;
                if (rxs_prev_q && !rxs_q) begin
                    state_d = START;
                end
            end

            START: begin
                if (decide && vote) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end

            DATA: begin
                if (decide) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                end
                if (bit_end) begin
                    if (bit_idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (decide) begin
                    par_err_d = vote ^ (^shift_q);
                end
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif

            STOP: begin
                // Return to IDLE at mid-stop so a start bit that follows
                // immediately is still caught.
                if (decide) begin
                    state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                    if (vote && !par_err_q) begin
`else
                    if (vote) begin
`endif
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any frame without a pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            samp_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            vote_a_q  <= 1'b0;
            vote_b_q  <= 1'b0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            samp_q    <= samp_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            vote_a_q  <= vote_a_d;
            vote_b_q  <= vote_b_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    assign rx_if.rx_data   = data_q;
    assign rx_if.rx_busy   = busy_q;
    assign rx_if.rx_valid  = valid_q;
    assign rx_if.frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx at CLK_FREQ=1.6 MHz, BAUD=10 kbaud,
// OVERSAMPLE=16 (DIV=10, 160 clocks per bit). Honours UART_RX_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CLK_FREQ   = 1_600_000;
    localparam int BAUD       = 10_000;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLK    = 160;

`ifdef UART_RX_PARITY_EN
    localparam int EXTRA_BITS = 1;
`else
    localparam int EXTRA_BITS = 0;
`endif
    localparam int FRAME_BITS = 10 + EXTRA_BITS;
    // Stop-bit decision: 3 clk edge detect + 10 clk to first tick, then
    // tick 9 of the stop bit: 3 + (FRAME_BITS-1)*160 + 100.
    localparam int VALID_LAT  = 3 + (FRAME_BITS - 1) * BIT_CLK + 100;
    localparam int FRAME_CLK  = FRAME_BITS * BIT_CLK;

    logic clk = 1'b0;
    logic reset;
    logic rxd;

    uart_rx_if rx_if ();

    uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rxd   (rxd),
        .rx_if (rx_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts high cycles of each pulse, so a stretched pulse
    // shows up as an extra count.
    int validCnt     = 0;
    int errCnt       = 0;
    int lastValidCyc = 0;
    int prevValidCyc = 0;
    always @(negedge clk) begin
        if (rx_if.rx_valid) begin
            validCnt     = validCnt + 1;
            prevValidCyc = lastValidCyc;
            lastValidCyc = cyc;
        end
        if (rx_if.frame_err) begin
            errCnt = errCnt + 1;
        end
    end

    int vectors     = 0;
    int miscompares = 0;
    int startCyc    = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors = vectors + 1;
        assert (observed === expected)
        else begin
            miscompares = miscompares + 1;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one frame starting at the current negedge and returns on the
    // negedge that ends the stop bit. parityFlip corrupts the parity bit;
    // glitchBit >= 0 inverts data bit glitchBit for 10 clk around its
    // early vote sample.
    task automatic applyStimulus(input logic [7:0] data, input int bitClk,
                                 input logic stopBit, input logic parityFlip,
                                 input int glitchBit);
        logic b;
        startCyc = cyc;
        for (int i = 0; i < FRAME_BITS; i++) begin
            if (i == 0)                 b = 1'b0;
            else if (i <= 8)            b = data[i-1];
            else if (i < FRAME_BITS - 1) b = (^data) ^ parityFlip;
            else                        b = stopBit;
            if ((i >= 1) && (i <= 8) && (i - 1 == glitchBit)) begin
                rxd = b;
                repeat (75) @(negedge clk);
                rxd = ~b;
                repeat (10) @(negedge clk);
                rxd = b;
                repeat (bitClk - 85) @(negedge clk);
            end else begin
                rxd = b;
                repeat (bitClk) @(negedge clk);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        rxd   = 1'b1;
        repeat (3) @(negedge clk);
        $display("[TB] reset values");
        checkOutput("rst_data",  rx_if.rx_data,   32'h00);
        checkOutput("rst_busy",  rx_if.rx_busy,   32'h0);
        checkOutput("rst_valid", rx_if.rx_valid,  32'h0);
        checkOutput("rst_ferr",  rx_if.frame_err, 32'h0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        $display("[TB] single byte A5");
        fork
            applyStimulus(8'hA5, BIT_CLK, 1'b1, 1'b0, -1);
            begin
                repeat (2) @(negedge clk);
                checkOutput("busy_start_plus2", rx_if.rx_busy, 32'h0);
                @(negedge clk);
                checkOutput("busy_start_plus3", rx_if.rx_busy, 32'h1);
            end
        join
        checkOutput("a5_data",    rx_if.rx_data, 32'hA5);
        checkOutput("a5_valid",   validCnt,      32'd1);
        checkOutput("a5_ferr",    errCnt,        32'd0);
        checkOutput("a5_latency", ((lastValidCyc - startCyc >= VALID_LAT - 3) &&
                                   (lastValidCyc - startCyc <= VALID_LAT + 3)), 32'h1);
        checkOutput("a5_busy_after", rx_if.rx_busy, 32'h0);

        $display("[TB] back-to-back 00 FF");
        applyStimulus(8'h00, BIT_CLK, 1'b1, 1'b0, -1);
        checkOutput("b2b_data0", rx_if.rx_data, 32'h00);
        applyStimulus(8'hFF, BIT_CLK, 1'b1, 1'b0, -1);
        checkOutput("b2b_data1", rx_if.rx_data,              32'hFF);
        checkOutput("b2b_valid", validCnt,                   32'd3);
        checkOutput("b2b_gap",   lastValidCyc - prevValidCyc, FRAME_CLK);
        checkOutput("b2b_ferr",  errCnt,                     32'd0);

        $display("[TB] bad stop bit then break");
        applyStimulus(8'h3C, BIT_CLK, 1'b0, 1'b0, -1);
        checkOutput("stop0_ferr",  errCnt,        32'd1);
        checkOutput("stop0_valid", validCnt,      32'd3);
        checkOutput("stop0_data",  rx_if.rx_data, 32'hFF);
        repeat (3 * BIT_CLK) @(negedge clk);
        checkOutput("break_ferr", errCnt,        32'd1);
        checkOutput("break_busy", rx_if.rx_busy, 32'h0);
        rxd = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        checkOutput("break_release_ferr",  errCnt,   32'd1);
        checkOutput("break_release_valid", validCnt, 32'd3);

        $display("[TB] 40 clk idle glitch");
        rxd = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("glitch_busy_hi", rx_if.rx_busy, 32'h1);
        repeat (30) @(negedge clk);
        rxd = 1'b1;
        repeat (150) @(negedge clk);
        checkOutput("glitch_busy_lo", rx_if.rx_busy, 32'h0);
        checkOutput("glitch_valid",   validCnt,      32'd3);
        checkOutput("glitch_ferr",    errCnt,        32'd1);
        applyStimulus(8'h5A, BIT_CLK, 1'b1, 1'b0, -1);
        checkOutput("after_glitch_data",  rx_if.rx_data, 32'h5A);
        checkOutput("after_glitch_valid", validCnt,      32'd4);

        $display("[TB] mid-bit glitch on bit 3");
        applyStimulus(8'h00, BIT_CLK, 1'b1, 1'b0, 3);
        checkOutput("midbit_data",  rx_if.rx_data, 32'h00);
        checkOutput("midbit_valid", validCnt,      32'd5);

        $display("[TB] baud error -3 and +3 percent");
        applyStimulus(8'hC3, 155, 1'b1, 1'b0, -1);
        checkOutput("fast_data",  rx_if.rx_data, 32'hC3);
        checkOutput("fast_valid", validCnt,      32'd6);
        repeat (50) @(negedge clk);
        applyStimulus(8'hC3, 165, 1'b1, 1'b0, -1);
        checkOutput("slow_data",  rx_if.rx_data, 32'hC3);
        checkOutput("slow_valid", validCnt,      32'd7);
        checkOutput("slow_ferr",  errCnt,        32'd1);

        $display("[TB] reset during DATA of 77");
        repeat (50) @(negedge clk);
        fork
            applyStimulus(8'h77, BIT_CLK, 1'b1, 1'b0, -1);
            begin
                repeat (500) @(negedge clk);
                checkOutput("pre_reset_busy", rx_if.rx_busy, 32'h1);
                #1 reset = 1'b1;
                #1;
                checkOutput("async_rst_data",  rx_if.rx_data,   32'h00);
                checkOutput("async_rst_busy",  rx_if.rx_busy,   32'h0);
                checkOutput("async_rst_valid", rx_if.rx_valid,  32'h0);
                checkOutput("async_rst_ferr",  rx_if.frame_err, 32'h0);
            end
        join
        repeat (20) @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        checkOutput("rst_abort_valid", validCnt, 32'd7);
        checkOutput("rst_abort_ferr",  errCnt,   32'd1);
        applyStimulus(8'h11, BIT_CLK, 1'b1, 1'b0, -1);
        checkOutput("post_rst_data",  rx_if.rx_data, 32'h11);
        checkOutput("post_rst_valid", validCnt,      32'd8);

`ifdef UART_RX_PARITY_EN
        $display("[TB] parity error on 01");
        repeat (50) @(negedge clk);
        applyStimulus(8'h01, BIT_CLK, 1'b1, 1'b1, -1);
        checkOutput("parity_ferr",  errCnt,        32'd2);
        checkOutput("parity_valid", validCnt,      32'd8);
        checkOutput("parity_data",  rx_if.rx_data, 32'h11);
`endif

        repeat (20) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
